// File: rtl/mux_df4_1.sv
// Four-to-one multiplexer with a dataflow select network and an optional
// output register (REG_OUT=1) or a purely combinational output (REG_OUT=0).
module mux_df4_1 #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i0,
  input  logic             s1,
  input  logic             s0,
  output logic [WIDTH-1:0] out
);

  logic [3:0]       dec;
  logic             sel_known;
  logic [WIDTH-1:0] sel_d;

  // One-hot decode of {s1,s0}; exactly one term is active for known selects.
  assign dec = {s1 & s0, s1 & ~s0, ~s1 & s0, ~s1 & ~s0};

  // An unknown select must poison the whole word, not just differing bits.
  assign sel_known = ((^{s1, s0}) !== 1'bx);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign sel_d[gi] = sel_known
                       ? ((dec[0] & i0[gi]) | (dec[1] & i1[gi]) |
                          (dec[2] & i2[gi]) | (dec[3] & i3[gi]))
                       : 1'bx;
    end
  endgenerate

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] out_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_q <= '0;
        end else begin
          out_q <= sel_d;
        end
      end

      assign out = out_q;
    end else begin : g_comb
      assign out = sel_d;
    end
  endgenerate

endmodule

// File: tb/tb_mux_df4_1.sv
// Scoreboard bench: one registered WIDTH=1 instance and one combinational
// WIDTH=8 instance, driven with directed vectors.
module tb_mux_df4_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Registered instance
  logic       r_rst;
  logic [3:0] r_i;
  logic [1:0] r_s;
  logic [0:0] r_out;

  // Combinational instance
  logic       c_rst;
  logic [7:0] c_i3, c_i2, c_i1, c_i0;
  logic [1:0] c_s;
  logic [7:0] c_out;

  mux_df4_1 #(.WIDTH(1), .REG_OUT(1)) u_reg (
    .clk(clk), .rst(r_rst),
    .i3(r_i[3]), .i2(r_i[2]), .i1(r_i[1]), .i0(r_i[0]),
    .s1(r_s[1]), .s0(r_s[0]), .out(r_out)
  );

  mux_df4_1 #(.WIDTH(8), .REG_OUT(0)) u_cmb (
    .clk(clk), .rst(c_rst),
    .i3(c_i3), .i2(c_i2), .i1(c_i1), .i0(c_i0),
    .s1(c_s[1]), .s0(c_s[0]), .out(c_out)
  );

  typedef struct {
    logic [7:0] exp;
    string      name;
  } sb_t;

  sb_t  rq[$];
  sb_t  cq[$];
  event c_ev;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: out=%h at %0t", name, act, $time);
    end
  endtask

  // Registered monitor: each pushed expectation is due just after the next edge.
  always @(posedge clk) begin
    #1;
    if (rq.size() > 0) begin
      sb_t e;
      e = rq.pop_front();
      check(e.name, {7'd0, r_out}, e.exp);
    end
  end

  // Combinational monitor: triggered after each combinational stimulus.
  always @(c_ev) begin
    #1;
    if (cq.size() > 0) begin
      sb_t e;
      e = cq.pop_front();
      check(e.name, c_out, e.exp);
    end
  end

  task automatic step(input string name, input logic rst_v, input logic [1:0] s_v,
                      input logic [3:0] d_v, input logic exp_v);
    sb_t e;
    @(negedge clk);
    r_rst = rst_v;
    r_s   = s_v;
    r_i   = d_v;
    e.exp  = {7'd0, exp_v};
    e.name = name;
    rq.push_back(e);
  endtask

  task automatic cstep(input string name, input logic [1:0] s_v, input logic [7:0] exp_v);
    sb_t e;
    c_s    = s_v;
    e.exp  = exp_v;
    e.name = name;
    cq.push_back(e);
    -> c_ev;
    #3;
  endtask

  initial begin
    r_rst = 1'b1; r_s = 2'b00; r_i = 4'h0;
    c_rst = 1'b1; c_s = 2'b00;
    c_i0 = 8'hA5; c_i1 = 8'h3C; c_i2 = 8'hFF; c_i3 = 8'h00;

    // Reset holds out low even with i3 selected and high, then loads on release
    step("reset_hold0", 1'b1, 2'b11, 4'b1000, 1'b0);
    step("reset_hold1", 1'b1, 2'b11, 4'b1000, 1'b0);
    step("reset_release", 1'b0, 2'b11, 4'b1000, 1'b1);

    // Latency: select change is invisible until the following edge
    step("lat_pre", 1'b0, 2'b00, 4'b0010, 1'b0);
    @(posedge clk); #2;
    step("lat_post", 1'b0, 2'b01, 4'b0010, 1'b1);
    #1;
    check("lat_before_edge", {7'd0, r_out}, 8'h00);

    // Unselected inputs toggling every cycle
    for (int k = 0; k < 6; k++) begin
      logic t;
      t = k[0];
      step("isolation", 1'b0, 2'b00, {t, ~t, t, 1'b1}, 1'b1);
    end

    // Select and data change together
    step("simul_a", 1'b0, 2'b00, 4'b0001, 1'b1);
    step("simul_b", 1'b0, 2'b10, 4'b0100, 1'b1);
    step("simul_c", 1'b0, 2'b11, 4'b0111, 1'b0);

    // Mid-operation reset: asserting between edges must not touch out
    step("mid_pre", 1'b0, 2'b11, 4'b1000, 1'b1);
    step("mid_rst", 1'b1, 2'b11, 4'b1000, 1'b0);
    #1;
    check("mid_rst_between_edges", {7'd0, r_out}, 8'h01);
    step("mid_after", 1'b0, 2'b11, 4'b1000, 1'b1);
    step("mid_after2", 1'b0, 2'b11, 4'b1000, 1'b1);

    // Exhaustive WIDTH=1 sweep, each vector held 5 cycles
    for (int s = 0; s < 4; s++) begin
      for (int d = 0; d < 16; d++) begin
        logic [3:0] dv;
        logic [1:0] sv;
        dv = d[3:0];
        sv = s[1:0];
        for (int h = 0; h < 5; h++) begin
          step($sformatf("sweep_s%0d_d%h_h%0d", s, dv, h), 1'b0, sv, dv, dv[sv]);
        end
      end
    end

    // Combinational instance: no edge needed, rst held high has no effect
    @(negedge clk);
    cstep("comb_sel0", 2'b00, 8'hA5);
    cstep("comb_sel1", 2'b01, 8'h3C);
    cstep("comb_sel2", 2'b10, 8'hFF);
    cstep("comb_sel3", 2'b11, 8'h00);
    c_rst = 1'b0;
    c_i3  = 8'h5A;
    cstep("comb_sel3_newdata", 2'b11, 8'h5A);
    cstep("comb_sel0_again", 2'b00, 8'hA5);

    // Drain the scoreboards within a bounded number of cycles
    begin
      int waited;
      waited = 0;
      while ((rq.size() > 0 || cq.size() > 0) && waited < 20) begin
        @(posedge clk);
        waited++;
      end
      @(negedge clk);
      n_cmp++;
      if (rq.size() != 0 || cq.size() != 0) begin
        n_bad++;
        $display("FAIL drain: pending reg=%0d comb=%0d expected 0", rq.size(), cq.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
